// File: rtl/global_types.sv
// Shared encodings for the hazard scoreboard: result-select code, forward selects, FSM states.
package global_types;

    localparam logic [2:0] SEL_RESULT_RD = 3'd2;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/forward_unit.sv
// Bypass select for one ALU operand; the M stage wins over W because it holds the younger result.
module forward_unit
    import global_types::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] m_wa,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] w_wa,
    input  logic              w_we,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (m_we && (m_wa == src))      sel = FWD_M;
            else if (w_we && (w_wa == src)) sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: operand forwarding, load-use and MDU-busy stalls, branch flush.
// Optional saturating stall/flush statistics are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
    import global_types::*;
#(
    parameter int ADDR_W            = 6,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MDU_LATENCY       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [ADDR_W-1:0] e_rs,
    input  logic [ADDR_W-1:0] e_rt,
    input  logic [ADDR_W-1:0] e_rf_wa,
    input  logic [ADDR_W-1:0] m_rf_wa,
    input  logic [ADDR_W-1:0] w_rf_wa,
    input  logic              e_rf_we,
    input  logic              m_rf_we,
    input  logic              w_rf_we,
    input  logic [2:0]        e_sel_result,
    input  logic              e_mdu_start,
    input  logic              d_uses_mdu,
    input  logic              e_branch_taken,
    output logic [1:0]        sel_forward_alu_a,
    output logic [1:0]        sel_forward_alu_b,
    output logic              f_stall,
    output logic              d_stall,
    output logic              e_flush,
    output logic              d_flush,
    output logic              mdu_busy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
);

    hz_state_e  state_q, state_d;
    logic [2:0] load_cnt_q, load_cnt_d;
    logic [4:0] mdu_cnt_q, mdu_cnt_d;
    logic       load_use;
    logic       stall;

    forward_unit #(.ADDR_W(ADDR_W)) u_fwd_a (
        .src (e_rs),
        .m_wa(m_rf_wa),
        .m_we(m_rf_we),
        .w_wa(w_rf_wa),
        .w_we(w_rf_we),
        .sel (sel_forward_alu_a)
    );

    forward_unit #(.ADDR_W(ADDR_W)) u_fwd_b (
        .src (e_rt),
        .m_wa(m_rf_wa),
        .m_we(m_rf_we),
        .w_wa(w_rf_wa),
        .w_we(w_rf_we),
        .sel (sel_forward_alu_b)
    );

    // A taken branch squashes D anyway, so it overrides every stall in its cycle.
    always_comb begin
        load_use = (e_sel_result == SEL_RESULT_RD) && e_rf_we && (e_rf_wa != '0) &&
                   ((e_rf_wa == d_rs) || (e_rf_wa == d_rt));
        mdu_busy = (mdu_cnt_q != '0);
        stall    = !e_branch_taken &&
                   ((state_q == LOAD_WAIT) || load_use || (d_uses_mdu && mdu_busy));
        f_stall  = stall;
        d_stall  = stall;
        e_flush  = stall;
        d_flush  = e_branch_taken;
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        if (e_branch_taken) begin
            state_d    = IDLE;
            load_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                        state_d    = LOAD_WAIT;
                        load_cnt_d = 3'(LOAD_STALL_CYCLES - 1);
                    end
                end
                LOAD_WAIT: begin
                    load_cnt_d = load_cnt_q - 3'd1;
                    if (load_cnt_q == 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A new MDU op restarts the count; a flushed start never reaches the unit.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (e_mdu_start && !e_flush) mdu_cnt_d = 5'(MDU_LATENCY);
        else if (mdu_busy)           mdu_cnt_d = mdu_cnt_q - 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            mdu_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            mdu_cnt_q  <= mdu_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (f_stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
        if (d_flush && (flush_events_q != 32'hFFFF_FFFF)) flush_events_d = flush_events_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
